// File: rtl/dds_pkg.sv
// Shared definitions for the DDS synthesis chain and its FCW estimator:
// default phase width, estimator state encoding and divider timing.
package dds_pkg;

  localparam int unsigned DDS_PHASE_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE,
    DONE
  } fcw_state_e;

  // Quotient width of 2^(phase_w+avg_log2) / D, which is also the divide cycle count.
  function automatic int unsigned div_cycles(input int unsigned phase_w,
                                             input int unsigned avg_log2);
    return phase_w + avg_log2 + 1;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring bit-serial divider: one quotient bit per clock, MSB first.
// done is high during the final step; quotient is complete from the next cycle.
module serial_divider #(
  parameter int unsigned NUM_W = 27,
  parameter int unsigned DEN_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int unsigned IDX_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  logic [DEN_W:0]   rem_q;
  logic [DEN_W-1:0] den_q;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] quo_q;
  logic [IDX_W-1:0] idx_q;
  logic             active_q;

  logic [DEN_W+1:0] trial;
  logic [DEN_W+1:0] diff;
  logic             fits;
  logic [DEN_W:0]   rem_next;
  logic             unused_trial_msb;

  // The remainder stays below D, so the shifted trial is below 2^(DEN_W+1)
  // and the sign of the difference is a reliable "trial >= D" flag.
  assign trial            = {rem_q, num_q[NUM_W-1]};
  assign diff             = trial - {2'b00, den_q};
  assign fits             = ~diff[DEN_W+1];
  assign rem_next         = fits ? diff[DEN_W:0] : trial[DEN_W:0];
  assign unused_trial_msb = trial[DEN_W+1];

  assign done     = active_q && (idx_q == '0);
  assign quotient = quo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q    <= '0;
      den_q    <= '0;
      num_q    <= '0;
      quo_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      den_q    <= denominator;
      num_q    <= numerator;
      quo_q    <= '0;
      idx_q    <= IDX_W'(NUM_W - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[NUM_W-2:0], fits};
      num_q <= {num_q[NUM_W-2:0], 1'b0};
      idx_q <= idx_q - 1'b1;
      if (idx_q == '0) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fcw_estimator.sv
// Reciprocal FCW estimator: times 2^AVG_LOG2 periods of sig_in, then FCW = 2^(PHASE_W+AVG_LOG2)/cycles.
// Optional macro FCW_IIR_EN enables first-order smoothing of successive estimates.
module fcw_estimator
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W     = DDS_PHASE_W,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sig_in,
  output logic [PHASE_W-1:0] fcw_out,
  output logic               fcw_valid,
  output logic               timeout,
  output logic               busy
);

  localparam int unsigned      NUM_W     = div_cycles(PHASE_W, AVG_LOG2);
  localparam logic [NUM_W-1:0] NUMERATOR = {1'b1, {(NUM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CYC_MAX   = '1;
  localparam int unsigned      EDGE_W    = AVG_LOG2 + 1;
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'((1 << AVG_LOG2) - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  fcw_state_e         state_q;
  logic [CNT_W-1:0]   cyc_cnt_q;
  logic [EDGE_W-1:0]  edge_cnt_q;
  logic [PHASE_W-1:0] fcw_out_q;
  logic               fcw_valid_q;
  logic               timeout_q;

  logic               timeout_hit;
  logic               div_start;
  logic               div_done;
  logic [NUM_W-1:0]   div_quot;
  logic [PHASE_W-1:0] q_sat;
  logic [PHASE_W-1:0] fcw_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Timeout takes priority over a coincident rise.
  assign timeout_hit = ((state_q == IDLE) || (state_q == MEASURE)) && (cyc_cnt_q == CYC_MAX);
  assign div_start   = (state_q == MEASURE) && rise && (edge_cnt_q == EDGE_LAST) && !timeout_hit;

  serial_divider #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (div_start),
    .numerator   (NUMERATOR),
    .denominator (cyc_cnt_q + 1'b1),
    .done        (div_done),
    .quotient    (div_quot)
  );

  assign q_sat = (|div_quot[NUM_W-1:PHASE_W]) ? '1 : div_quot[PHASE_W-1:0];

`ifdef FCW_IIR_EN
  logic signed [PHASE_W:0] iir_diff;
  logic signed [PHASE_W:0] iir_step;
  logic                    unused_iir_sign;

  assign iir_diff        = $signed({1'b0, q_sat}) - $signed({1'b0, fcw_out_q});
  assign iir_step        = iir_diff >>> 2;
  assign fcw_next        = fcw_out_q + iir_step[PHASE_W-1:0];
  assign unused_iir_sign = iir_step[PHASE_W];
`else
  assign fcw_next = q_sat;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      fcw_out_q   <= '0;
      fcw_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      fcw_valid_q <= 1'b0;
      if (timeout_hit) begin
        state_q     <= IDLE;
        cyc_cnt_q   <= '0;
        edge_cnt_q  <= '0;
        fcw_out_q   <= '0;
        timeout_q   <= 1'b1;
        fcw_valid_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) begin
              cyc_cnt_q  <= '0;
              edge_cnt_q <= '0;
              state_q    <= MEASURE;
            end else begin
              cyc_cnt_q <= cyc_cnt_q + 1'b1;
            end
          end
          MEASURE: begin
            if (div_start) begin
              cyc_cnt_q  <= '0;
              edge_cnt_q <= '0;
              state_q    <= DIVIDE;
            end else begin
              cyc_cnt_q <= cyc_cnt_q + 1'b1;
              if (rise) edge_cnt_q <= edge_cnt_q + 1'b1;
            end
          end
          DIVIDE: begin
            if (div_done) state_q <= DONE;
          end
          DONE: begin
            fcw_out_q   <= fcw_next;
            timeout_q   <= 1'b0;
            fcw_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fcw_out   = fcw_out_q;
  assign fcw_valid = fcw_valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fcw_estimator.sv
// Directed bench for fcw_estimator (default build): a default instance plus a CNT_W=10 instance for timeouts.
module tb_fcw_estimator;

  localparam int unsigned PW = 24;

  logic          clk;
  logic          reset;
  logic          sig_in;
  logic [PW-1:0] fcw_out, fcw_out_s;
  logic          fcw_valid, fcw_valid_s;
  logic          timeout, timeout_s;
  logic          busy, busy_s;

  fcw_estimator dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .fcw_out   (fcw_out),
    .fcw_valid (fcw_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  fcw_estimator #(.CNT_W(10)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .fcw_out   (fcw_out_s),
    .fcw_valid (fcw_valid_s),
    .timeout   (timeout_s),
    .busy      (busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Valid-pulse monitors for both instances.
  int unsigned   n_valid = 0, n_valid_s = 0;
  int unsigned   valid_cyc = 0, valid_cyc_s = 0, prev_cyc_s = 0;
  logic [PW-1:0] last_fcw = '0, last_fcw_s = '0;
  logic          last_to = 1'b0, last_to_s = 1'b0;

  always @(negedge clk) begin
    if (fcw_valid === 1'b1) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
      last_fcw  <= fcw_out;
      last_to   <= timeout;
    end
    if (fcw_valid_s === 1'b1) begin
      n_valid_s   <= n_valid_s + 1;
      prev_cyc_s  <= valid_cyc_s;
      valid_cyc_s <= cyc;
      last_fcw_s  <= fcw_out_s;
      last_to_s   <= timeout_s;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int unsigned rel_cyc   = 0;
  int unsigned rise5_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n periods of a square wave, each starting with a rising edge.
  task automatic wave(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in    = 1'b1;
      rise5_cyc = cyc;
      step(half);
      sig_in = 1'b0;
      step(half);
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    step(3);
    check("rst_fcw_out",   32'(fcw_out),   32'h0);
    check("rst_fcw_valid", 32'(fcw_valid), 32'h0);
    check("rst_timeout",   32'(timeout),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_busy_s",    32'(busy_s),    32'h0);

    // Static low input: the CNT_W=10 instance times out every 1024 cycles.
    @(negedge clk);
    reset   = 1'b0;
    rel_cyc = cyc;
    step(1030);
    check("to1_count",  32'(n_valid_s),             32'd1);
    check("to1_cycle",  32'(valid_cyc_s - rel_cyc), 32'd1024);
    check("to1_fcw",    32'(last_fcw_s),            32'h0);
    check("to1_flag",   32'(last_to_s),             32'h1);
    check("to_held",    32'(timeout_s),             32'h1);
    check("main_no_to", 32'(n_valid),               32'd0);
    step(1024);
    check("to2_count",  32'(n_valid_s),                32'd2);
    check("to2_period", 32'(valid_cyc_s - prev_cyc_s), 32'd1024);

    // 16-clock period: D=64 -> 2^26/64.
    wave(8, 5);
    step(40);
    check("p16_count",   32'(n_valid),               32'd1);
    check("p16_fcw",     32'(last_fcw),              32'h100000);
    check("p16_to",      32'(last_to),               32'h0);
    check("p16_latency", 32'(valid_cyc - rise5_cyc), 32'd31);
    check("p16_s_fcw",   32'(last_fcw_s),            32'h100000);
    check("p16_s_to",    32'(timeout_s),             32'h0);
    step(20);
    check("p16_hold",    32'(fcw_out),               32'h100000);
    check("p16_idle_v",  32'(fcw_valid),             32'h0);

    // 10-clock period: D=40 -> floor(2^26/40).
    wave(5, 5);
    step(40);
    check("p10_count", 32'(n_valid),  32'd2);
    check("p10_fcw",   32'(last_fcw), 32'h199999);
    check("p10_to",    32'(last_to),  32'h0);

    // Minimum 2-clock period: D=8 -> 2^23, just below saturation.
    wave(1, 5);
    step(40);
    check("p2_count", 32'(n_valid),  32'd3);
    check("p2_fcw",   32'(last_fcw), 32'h800000);

    // Reset pulse mid-DIVIDE aborts with no valid pulse.
    wave(8, 5);
    check("div_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("abort_fcw",   32'(fcw_out),   32'h0);
    check("abort_valid", 32'(fcw_valid), 32'h0);
    check("abort_to",    32'(timeout),   32'h0);
    check("abort_busy",  32'(busy),      32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(40);
    check("abort_no_valid", 32'(n_valid), 32'd3);
    wave(8, 5);
    step(40);
    check("rec_count", 32'(n_valid),  32'd4);
    check("rec_fcw",   32'(last_fcw), 32'h100000);
    check("rec_to",    32'(last_to),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
